// File: rtl/gemm_drain_pkg.sv
// Shared types for the GEMM C drain: FSM state encoding and the stream beat record.
package gemm_drain_pkg;

    localparam int DrainDataWidth = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        FLUSH,
        DONE
    } drain_state_e;

    typedef struct packed {
        logic [DrainDataWidth-1:0] data;
        logic                      row_last;
        logic                      last;
    } beat_t;

endpackage

// File: rtl/gemm_c_drain_if.sv
// Output stream of the C drain: valid/ready beat with row and matrix end flags.
interface gemm_c_drain_if #(
    parameter int DataWidth = 32
);
    logic                 m_valid_o;
    logic                 m_ready_i;
    logic [DataWidth-1:0] m_data_o;
    logic                 m_row_last_o;
    logic                 m_last_o;

    modport master (
        output m_valid_o,
        output m_data_o,
        output m_row_last_o,
        output m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_valid_o,
        input  m_data_o,
        input  m_row_last_o,
        input  m_last_o,
        output m_ready_i
    );
endinterface

// File: rtl/gemm_drain_fifo.sv
// Small synchronous FIFO of drain beats; head is read straight from storage flops.
module gemm_drain_fifo
    import gemm_drain_pkg::*;
#(
    parameter  int Depth = 2,
    localparam int CntW  = $clog2(Depth + 1),
    localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push,
    input  beat_t           push_data,
    input  logic            pop,
    output beat_t           head,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    beat_t           mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CntW'(1);
            end else if (pop && !push) begin
                count <= count - CntW'(1);
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CntW'(Depth));
    assign empty = (count == '0);

endmodule

// File: rtl/gemm_c_drain.sv
// Drains GEMM output SRAM C row-major from base_addr_i onto a valid/ready stream.
// Defining GEMM_DRAIN_CHECKSUM_EN adds checksum_o, the wrapping sum of drained beats.
module gemm_c_drain
    import gemm_drain_pkg::*;
#(
    parameter int OutDataWidth  = DrainDataWidth,
    parameter int AddrWidth     = 12,
    parameter int SizeAddrWidth = 8,
    parameter int FifoDepth     = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    input  logic [AddrWidth-1:0]     base_addr_i,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_re_o,
    input  logic [OutDataWidth-1:0]  sram_c_rdata_i,
    gemm_c_drain_if.master           m_if,
    output logic                     busy_o,
    output logic                     done_o
`ifdef GEMM_DRAIN_CHECKSUM_EN
    ,
    output logic [OutDataWidth-1:0]  checksum_o
`endif
);

    localparam int CntW = $clog2(FifoDepth + 1);

    drain_state_e             state_q;
    logic [SizeAddrWidth-1:0] m_size_q;
    logic [SizeAddrWidth-1:0] n_size_q;
    logic [SizeAddrWidth-1:0] row_q;
    logic [SizeAddrWidth-1:0] col_q;
    logic [AddrWidth-1:0]     addr_q;
    logic                     inflight_q;
    logic                     tag_row_last_q;
    logic                     tag_last_q;
    logic                     busy_q;
    logic                     done_q;

    logic                     re;
    logic                     pop;
    logic                     rd_row_last;
    logic                     rd_last;
    logic                     size_zero;
    logic                     flush_done;
    logic [CntW:0]            pending;
    beat_t                    push_beat;
    beat_t                    head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CntW-1:0]          fifo_count;

    assign pop         = m_if.m_valid_o && m_if.m_ready_i;
    assign rd_row_last = (col_q == n_size_q - SizeAddrWidth'(1));
    assign rd_last     = rd_row_last && (row_q == m_size_q - SizeAddrWidth'(1));
    assign size_zero   = (M_size_i == '0) || (N_size_i == '0);

    // Credit: entries held plus reads in flight, less this cycle's pop, must leave room.
    assign pending = {1'b0, fifo_count} + (CntW+1)'(inflight_q) - (CntW+1)'(pop);
    assign re      = (state_q == ISSUE) && (pending < (CntW+1)'(FifoDepth));

    // DONE is entered on the cycle the last beat leaves, so done_o lands one cycle later.
    assign flush_done = !inflight_q &&
                        ((fifo_count == '0) || ((fifo_count == CntW'(1)) && pop));

    // Zero-size drains spend one cycle in FLUSH, which finds nothing to wait for.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            m_size_q       <= '0;
            n_size_q       <= '0;
            row_q          <= '0;
            col_q          <= '0;
            addr_q         <= '0;
            inflight_q     <= 1'b0;
            tag_row_last_q <= 1'b0;
            tag_last_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q         <= 1'b0;
            inflight_q     <= re;
            tag_row_last_q <= rd_row_last;
            tag_last_q     <= rd_last;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        m_size_q <= M_size_i;
                        n_size_q <= N_size_i;
                        addr_q   <= base_addr_i;
                        row_q    <= '0;
                        col_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= size_zero ? FLUSH : ISSUE;
                    end
                end
                ISSUE: begin
                    if (re) begin
                        addr_q <= addr_q + AddrWidth'(1);
                        if (rd_row_last) begin
                            col_q <= '0;
                            row_q <= row_q + SizeAddrWidth'(1);
                        end else begin
                            col_q <= col_q + SizeAddrWidth'(1);
                        end
                        if (rd_last) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_done) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign push_beat.data     = sram_c_rdata_i;
    assign push_beat.row_last = tag_row_last_q;
    assign push_beat.last     = tag_last_q;

    gemm_drain_fifo #(
        .Depth(FifoDepth)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (inflight_q),
        .push_data(push_beat),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign m_if.m_valid_o    = !fifo_empty;
    assign m_if.m_data_o     = head.data;
    assign m_if.m_row_last_o = head.row_last;
    assign m_if.m_last_o     = head.last;

    assign sram_c_addr_o = addr_q;
    assign sram_c_re_o   = re;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

    a_no_push_when_full: assert property (
        @(posedge clk_i) disable iff (rst_i) !(inflight_q && fifo_full && !pop)
    );

`ifdef GEMM_DRAIN_CHECKSUM_EN
    logic [OutDataWidth-1:0] checksum_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            checksum_q <= '0;
        end else if ((state_q == IDLE) && start_i) begin
            checksum_q <= '0;
        end else if (pop) begin
            checksum_q <= checksum_q + m_if.m_data_o;
        end
    end

    assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_gemm_c_drain.sv
// Self-checking bench for gemm_c_drain against a queue-based model of the row-major sweep.
module tb_gemm_c_drain;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [SW-1:0] m_size;
    logic [SW-1:0] n_size;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] sram_addr;
    logic          sram_re;
    logic [DW-1:0] sram_rdata;
    logic          busy;
    logic          done;
`ifdef GEMM_DRAIN_CHECKSUM_EN
    logic [DW-1:0] checksum;
    logic [DW-1:0] cks_at_done;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] mem [0:4095];

    gemm_c_drain_if #(.DataWidth(DW)) m_if ();

    gemm_c_drain #(
        .OutDataWidth (DW),
        .AddrWidth    (AW),
        .SizeAddrWidth(SW),
        .FifoDepth    (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .M_size_i      (m_size),
        .N_size_i      (n_size),
        .base_addr_i   (base_addr),
        .sram_c_addr_o (sram_addr),
        .sram_c_re_o   (sram_re),
        .sram_c_rdata_i(sram_rdata),
        .m_if          (m_if),
        .busy_o        (busy),
        .done_o        (done)
`ifdef GEMM_DRAIN_CHECKSUM_EN
        ,
        .checksum_o    (checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (sram_re) sram_rdata <= mem[sram_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1);
    end

    task automatic fill_random(input logic [AW-1:0] base, input int count);
        logic [AW-1:0] a;
        for (int i = 0; i < count; i++) begin
            a = base + AW'(i);
            mem[a] = $urandom;
        end
    endtask

    // rmode: 0 ready held high, 1 ready toggling, 2 ready random
    task automatic run_drain(input string name, input int m, input int n,
                             input logic [AW-1:0] base, input int rmode, input bit mid_start);
        logic [DW-1:0] exp_data [$];
        bit            exp_rl [$];
        bit            exp_l [$];
        logic [AW-1:0] exp_addr [$];
        logic [AW-1:0] a;
        logic [DW-1:0] prev_data;
        bit            prev_rl, prev_l, prev_stall;
        int t0, first_re, first_valid, last_beat, done_cyc, beats;
`ifdef GEMM_DRAIN_CHECKSUM_EN
        logic [DW-1:0] sum = '0;
`endif
        first_re = -1; first_valid = -1; last_beat = -1; done_cyc = -1; beats = 0;
        prev_stall = 0; prev_data = '0; prev_rl = 0; prev_l = 0;
        for (int i = 0; i < m * n; i++) begin
            a = base + AW'(i);
            exp_addr.push_back(a);
            exp_data.push_back(mem[a]);
            exp_rl.push_back((i % n) == n - 1);
            exp_l.push_back(i == m * n - 1);
`ifdef GEMM_DRAIN_CHECKSUM_EN
            sum = sum + mem[a];
`endif
        end

        @(posedge clk); #1;
        start = 1'b1; m_size = SW'(m); n_size = SW'(n); base_addr = base;
        m_if.m_ready_i = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        t0 = cyc;
        for (int k = 0; k < m * n * 6 + 20 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (sram_re === 1'b1) begin
                if (first_re < 0) first_re = cyc;
                checks++;
                if (exp_addr.size() == 0) begin
                    failures++;
                    $display("FAIL %s extra_read: addr=%h issued after all reads", name, sram_addr);
                end else begin
                    if (sram_addr !== exp_addr[0]) begin
                        failures++;
                        $display("FAIL %s read_addr: got %h exp %h", name, sram_addr, exp_addr[0]);
                    end
                    void'(exp_addr.pop_front());
                end
            end
            if (prev_stall) begin
                checks++;
                if (m_if.m_valid_o !== 1'b1 || m_if.m_data_o !== prev_data ||
                    m_if.m_row_last_o !== prev_rl || m_if.m_last_o !== prev_l) begin
                    failures++;
                    $display("FAIL %s stall_hold: got v=%b d=%h rl=%b l=%b exp v=1 d=%h rl=%b l=%b",
                             name, m_if.m_valid_o, m_if.m_data_o, m_if.m_row_last_o, m_if.m_last_o,
                             prev_data, prev_rl, prev_l);
                end
            end
            if (m_if.m_valid_o === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                if (m_if.m_ready_i === 1'b1) begin
                    checks++;
                    if (exp_data.size() == 0) begin
                        failures++;
                        $display("FAIL %s extra_beat: got d=%h, no beat expected", name, m_if.m_data_o);
                    end else begin
                        if (m_if.m_data_o !== exp_data[0] || m_if.m_row_last_o !== exp_rl[0] ||
                            m_if.m_last_o !== exp_l[0]) begin
                            failures++;
                            $display("FAIL %s beat%0d: got d=%h rl=%b l=%b exp d=%h rl=%b l=%b",
                                     name, beats, m_if.m_data_o, m_if.m_row_last_o, m_if.m_last_o,
                                     exp_data[0], exp_rl[0], exp_l[0]);
                        end
                        void'(exp_data.pop_front());
                        void'(exp_rl.pop_front());
                        void'(exp_l.pop_front());
                    end
                    if (rmode == 0 && last_beat >= 0) begin
                        checks++;
                        if (cyc != last_beat + 1) begin
                            failures++;
                            $display("FAIL %s bubble: beat at cycle %0d exp %0d", name, cyc, last_beat + 1);
                        end
                    end
                    last_beat = cyc;
                    beats++;
                end
            end
            prev_stall = (m_if.m_valid_o === 1'b1) && (m_if.m_ready_i === 1'b0);
            prev_data  = m_if.m_data_o;
            prev_rl    = m_if.m_row_last_o;
            prev_l     = m_if.m_last_o;
            if (done === 1'b1) begin
                done_cyc = cyc;
`ifdef GEMM_DRAIN_CHECKSUM_EN
                cks_at_done = checksum;
`endif
            end
            @(posedge clk); #1;
            if (mid_start && cyc == t0 + 4) begin
                start = 1'b1; m_size = 8'd7; n_size = 8'd7; base_addr = base + AW'(100);
            end else begin
                start = 1'b0;
            end
            case (rmode)
                0:       m_if.m_ready_i = 1'b1;
                1:       m_if.m_ready_i = (cyc % 2) == 0;
                default: m_if.m_ready_i = 1'($urandom_range(0, 1));
            endcase
        end

        checks++;
        if (done_cyc < 0) begin
            failures++;
            $display("FAIL %s done_timeout: done_o never seen, beats=%0d exp %0d", name, beats, m * n);
        end
        checks++;
        if (beats != m * n || exp_data.size() != 0 || exp_addr.size() != 0) begin
            failures++;
            $display("FAIL %s count: got beats=%0d exp %0d (reads left %0d)", name, beats, m * n,
                     exp_addr.size());
        end
        checks++;
        if (first_re != t0 + 1) begin
            failures++;
            $display("FAIL %s first_re: got cycle %0d exp %0d", name, first_re, t0 + 1);
        end
        checks++;
        if (first_valid != t0 + 3) begin
            failures++;
            $display("FAIL %s first_valid: got cycle %0d exp %0d", name, first_valid, t0 + 3);
        end
        checks++;
        if (done_cyc != last_beat + 1) begin
            failures++;
            $display("FAIL %s done_timing: got cycle %0d exp %0d", name, done_cyc, last_beat + 1);
        end
`ifdef GEMM_DRAIN_CHECKSUM_EN
        checks++;
        if (cks_at_done !== sum) begin
            failures++;
            $display("FAIL %s checksum: got %h exp %h", name, cks_at_done, sum);
        end
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: got done=%b busy=%b exp 0 0", name, done, busy);
        end
        m_if.m_ready_i = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; m_size = '0; n_size = '0; base_addr = '0;
        m_if.m_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_if.m_valid_o !== 1'b0 || sram_re !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            sram_addr !== '0 || m_if.m_data_o !== '0 || m_if.m_row_last_o !== 1'b0 ||
            m_if.m_last_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got v=%b re=%b busy=%b done=%b addr=%h d=%h exp all 0",
                     m_if.m_valid_o, sram_re, busy, done, sram_addr, m_if.m_data_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        for (int i = 0; i < 6; i++) mem[12'h100 + i] = 32'(i + 1);
        run_drain("basic", 2, 3, 12'h100, 0, 1'b0);
    endtask

    task automatic test_stall;
        run_drain("stall", 2, 3, 12'h100, 1, 1'b0);
    endtask

    task automatic test_zero_size;
        int t0;
        @(posedge clk); #1;
        start = 1'b1; m_size = 8'd0; n_size = 8'd5; base_addr = 12'h200;
        m_if.m_ready_i = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (sram_re !== 1'b0 || m_if.m_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL zero_activity: cycle t0+%0d got re=%b valid=%b exp 0 0", k, sram_re,
                         m_if.m_valid_o);
            end
            checks++;
            if (busy !== 1'(k <= 2)) begin
                failures++;
                $display("FAIL zero_busy: cycle t0+%0d got %b exp %b", k, busy, 1'(k <= 2));
            end
            checks++;
            if (done !== 1'(k == 2)) begin
                failures++;
                $display("FAIL zero_done: cycle t0+%0d got %b exp %b", k, done, 1'(k == 2));
            end
        end
    endtask

    task automatic test_wrap;
        fill_random(12'hFFE, 4);
        run_drain("wrap", 1, 4, 12'hFFE, 0, 1'b1);
    endtask

    task automatic test_reset_mid;
        logic [AW-1:0] base;
        base = AW'($urandom);
        fill_random(base, 64);
        @(posedge clk); #1;
        start = 1'b1; m_size = 8'd8; n_size = 8'd8; base_addr = base;
        m_if.m_ready_i = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (m_if.m_valid_o !== 1'b0 || sram_re !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            sram_addr !== '0) begin
            failures++;
            $display("FAIL reset_mid: got v=%b re=%b busy=%b done=%b addr=%h exp all 0",
                     m_if.m_valid_o, sram_re, busy, done, sram_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_if.m_ready_i = 1'b1;
        run_drain("after_reset", 8, 8, base, 2, 1'b0);
    endtask

    task automatic test_random;
        int m, n;
        logic [AW-1:0] base;
        for (int t = 0; t < 6; t++) begin
            m = $urandom_range(1, 6);
            n = $urandom_range(1, 6);
            base = AW'($urandom);
            fill_random(base, m * n);
            run_drain("random", m, n, base, t % 3, 1'b0);
        end
    endtask

`ifdef GEMM_DRAIN_CHECKSUM_EN
    task automatic test_checksum;
        for (int i = 0; i < 16; i++) mem[12'h300 + i] = 32'h4000_0000;
        run_drain("checksum", 4, 4, 12'h300, 0, 1'b0);
        checks++;
        if (cks_at_done !== 32'h0000_0000) begin
            failures++;
            $display("FAIL checksum_wrap: got %h exp 00000000", cks_at_done);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_zero_size;
        test_wrap;
        test_reset_mid;
        test_random;
`ifdef GEMM_DRAIN_CHECKSUM_EN
        test_checksum;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
